// File: rtl/multi_issue_fifo_pkg.sv
// Shared defines for the multi-issue FIFO: default geometry and the issue-queue entry type.
package multi_issue_fifo_pkg;

  localparam int unsigned DEFAULT_DEPTH  = 16;
  localparam int unsigned DEFAULT_PUSH_W = 4;
  localparam int unsigned DEFAULT_POP_W  = 2;
  localparam int unsigned PERF_CNT_W     = 32;

  typedef struct packed {
    logic [5:0] rob_idx;
    logic [3:0] opcode;
    logic [5:0] dest;
  } ISSUE_QUEUE_ELEMENT;

endpackage

// File: rtl/fifo_ptr_add.sv
// Circular-buffer pointer plus offset, wrapping modulo a power-of-two DEPTH.
module fifo_ptr_add import multi_issue_fifo_pkg::*; #(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned OFF_W = $clog2(DEFAULT_DEPTH + 1)
) (
  input  logic [$clog2(DEPTH)-1:0] ptr,
  input  logic [OFF_W-1:0]         off,
  output logic [$clog2(DEPTH)-1:0] sum_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Power-of-two depth: dropping the carry is the modulo.
  assign sum_c = ptr + PTR_W'(off);

endmodule

// File: rtl/multi_issue_fifo.sv
// Multi-issue circular FIFO: up to PUSH_W all-or-nothing writes and POP_W clamped reads per cycle.
// Optional performance counters enabled by defining MULTI_ISSUE_FIFO_PERF_EN.
module multi_issue_fifo import multi_issue_fifo_pkg::*; #(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned PUSH_W = DEFAULT_PUSH_W,
  parameter int unsigned POP_W  = DEFAULT_POP_W,
  parameter type         ELEM_T = ISSUE_QUEUE_ELEMENT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [$clog2(PUSH_W+1)-1:0]   push_num,
  input  ELEM_T [PUSH_W-1:0]            push_data,
  input  logic [$clog2(POP_W+1)-1:0]    pop_num,
  output ELEM_T [POP_W-1:0]             pop_data,
  output logic [POP_W-1:0]              pop_valid,
  output logic [$clog2(DEPTH+1)-1:0]    size,
  output logic [$clog2(DEPTH+1)-1:0]    size_left,
  output logic                          push_reject,
  output logic [PERF_CNT_W-1:0]         full_cycles,
  output logic [PERF_CNT_W-1:0]         reject_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PN_W  = $clog2(PUSH_W + 1);

  ELEM_T             mem_q [DEPTH];
  ELEM_T             mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  size_q, size_d, size_left_q, size_left_d;
  logic              push_reject_q, push_reject_d;

  logic              push_ok_c;
  logic [CNT_W-1:0]  pop_eff_c;
  logic [PN_W-1:0]   push_adv_c;
  logic [PTR_W-1:0]  head_nxt_c, tail_nxt_c;
  logic [PTR_W-1:0]  wr_idx_c [PUSH_W];
  logic [PTR_W-1:0]  rd_idx_c [POP_W];

  for (genvar j = 0; j < PUSH_W; j++) begin : g_wr_idx
    fifo_ptr_add #(.DEPTH(DEPTH), .OFF_W(PTR_W)) u_wr_add (
      .ptr   (tail_q),
      .off   (PTR_W'(j)),
      .sum_c (wr_idx_c[j])
    );
  end

  for (genvar i = 0; i < POP_W; i++) begin : g_rd_idx
    fifo_ptr_add #(.DEPTH(DEPTH), .OFF_W(PTR_W)) u_rd_add (
      .ptr   (head_q),
      .off   (PTR_W'(i)),
      .sum_c (rd_idx_c[i])
    );
  end

  fifo_ptr_add #(.DEPTH(DEPTH), .OFF_W(CNT_W)) u_head_add (
    .ptr   (head_q),
    .off   (pop_eff_c),
    .sum_c (head_nxt_c)
  );

  fifo_ptr_add #(.DEPTH(DEPTH), .OFF_W(PN_W)) u_tail_add (
    .ptr   (tail_q),
    .off   (push_adv_c),
    .sum_c (tail_nxt_c)
  );

  // Admission judged on registered free space, before this cycle's pop frees anything.
  always_comb begin
    push_ok_c  = CNT_W'(push_num) <= size_left_q;
    pop_eff_c  = (CNT_W'(pop_num) < size_q) ? CNT_W'(pop_num) : size_q;
    push_adv_c = push_ok_c ? push_num : '0;
  end

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    size_d        = size_q;
    push_reject_d = 1'b0;
    mem_d         = mem_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      size_d = '0;
    end else begin
      head_d        = head_nxt_c;
      tail_d        = tail_nxt_c;
      size_d        = size_q + CNT_W'(push_adv_c) - pop_eff_c;
      push_reject_d = ~push_ok_c;
      for (int unsigned j = 0; j < PUSH_W; j++) begin
        if (push_ok_c && (PN_W'(j) < push_num)) mem_d[wr_idx_c[j]] = push_data[j];
      end
    end
    size_left_d = CNT_W'(DEPTH) - size_d;
  end

  always_comb begin
    for (int unsigned i = 0; i < POP_W; i++) begin
      pop_data[i]  = mem_q[rd_idx_c[i]];
      pop_valid[i] = CNT_W'(i) < size_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      size_q        <= '0;
      size_left_q   <= CNT_W'(DEPTH);
      push_reject_q <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      size_q        <= size_d;
      size_left_q   <= size_left_d;
      push_reject_q <= push_reject_d;
    end
  end

  // Storage is not reset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign size        = size_q;
  assign size_left   = size_left_q;
  assign push_reject = push_reject_q;

`ifdef MULTI_ISSUE_FIFO_PERF_EN
  logic [PERF_CNT_W-1:0] full_cycles_q, full_cycles_d;
  logic [PERF_CNT_W-1:0] reject_count_q, reject_count_d;

  // Saturating counters; flush leaves them alone.
  always_comb begin
    full_cycles_d  = full_cycles_q;
    reject_count_d = reject_count_q;
    if ((size_q == CNT_W'(DEPTH)) && (full_cycles_q != '1)) full_cycles_d = full_cycles_q + 1'b1;
    if (!flush && !push_ok_c && (reject_count_q != '1)) reject_count_d = reject_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_cycles_q  <= '0;
      reject_count_q <= '0;
    end else begin
      full_cycles_q  <= full_cycles_d;
      reject_count_q <= reject_count_d;
    end
  end

  assign full_cycles  = full_cycles_q;
  assign reject_count = reject_count_q;
`else
  assign full_cycles  = '0;
  assign reject_count = '0;
`endif

endmodule

// File: tb/tb_multi_issue_fifo.sv
// Self-checking bench for multi_issue_fifo: directed scenarios then random traffic against a queue model.
module tb_multi_issue_fifo;
  import multi_issue_fifo_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PUSH_W = 4;
  localparam int unsigned POP_W  = 2;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PN_W   = $clog2(PUSH_W + 1);
  localparam int unsigned PO_W   = $clog2(POP_W + 1);
`ifdef MULTI_ISSUE_FIFO_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           flush;
  logic [PN_W-1:0]                push_num;
  ISSUE_QUEUE_ELEMENT [PUSH_W-1:0] push_data;
  logic [PO_W-1:0]                pop_num;
  ISSUE_QUEUE_ELEMENT [POP_W-1:0] pop_data;
  logic [POP_W-1:0]               pop_valid;
  logic [CNT_W-1:0]               size;
  logic [CNT_W-1:0]               size_left;
  logic                           push_reject;
  logic [31:0]                    full_cycles;
  logic [31:0]                    reject_count;

  multi_issue_fifo #(
    .DEPTH  (DEPTH),
    .PUSH_W (PUSH_W),
    .POP_W  (POP_W),
    .ELEM_T (ISSUE_QUEUE_ELEMENT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .push_num     (push_num),
    .push_data    (push_data),
    .pop_num      (pop_num),
    .pop_data     (pop_data),
    .pop_valid    (pop_valid),
    .size         (size),
    .size_left    (size_left),
    .push_reject  (push_reject),
    .full_cycles  (full_cycles),
    .reject_count (reject_count)
  );

  always #5 clk = ~clk;

  ISSUE_QUEUE_ELEMENT mq[$];
  bit                 m_rej;
  int unsigned        m_full;
  int unsigned        m_rejcnt;
  int                 checks   = 0;
  int                 failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [POP_W-1:0] pv;
    for (int i = 0; i < POP_W; i++) pv[i] = (i < mq.size());
    chk({tag, ":size"},         64'(size),         64'(mq.size()));
    chk({tag, ":size_left"},    64'(size_left),    64'(DEPTH - mq.size()));
    chk({tag, ":push_reject"},  64'(push_reject),  64'(m_rej));
    chk({tag, ":pop_valid"},    64'(pop_valid),    64'(pv));
    for (int i = 0; i < POP_W; i++)
      if (i < mq.size()) chk($sformatf("%s:pop_data%0d", tag, i), 64'(pop_data[i]), 64'(mq[i]));
    chk({tag, ":full_cycles"},  64'(full_cycles),  PERF ? 64'(m_full)   : 64'd0);
    chk({tag, ":reject_count"}, 64'(reject_count), PERF ? 64'(m_rejcnt) : 64'd0);
  endtask

  // Applies one cycle of stimulus and advances the queue model by the same rules.
  task automatic cycle(input int pn, input int pp, input bit fl);
    int ep;
    bit ok;
    push_num = PN_W'(pn);
    pop_num  = PO_W'(pp);
    flush    = fl;
    for (int j = 0; j < PUSH_W; j++) push_data[j] = 16'($urandom);
    @(posedge clk);
    if (mq.size() == DEPTH) m_full++;
    if (fl) begin
      mq.delete();
      m_rej = 1'b0;
    end else begin
      ok = (pn <= int'(DEPTH) - mq.size());
      ep = (pp < mq.size()) ? pp : mq.size();
      repeat (ep) void'(mq.pop_front());
      if (ok) for (int j = 0; j < pn; j++) mq.push_back(push_data[j]);
      m_rej = !ok;
      if (!ok) m_rejcnt++;
    end
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_rej    = 1'b0;
    m_full   = 0;
    m_rejcnt = 0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push_num = '0; pop_num = '0; push_data = '0;
    model_reset();
    #12;
    check_all("reset_hold");
    @(negedge clk); rst = 1'b0; #1;
    check_all("reset_release");

    // Fill to full, then an overflowing push and the one-cycle reject pulse.
    repeat (4) begin cycle(4, 0, 0); check_all("fill"); end
    cycle(1, 0, 0); check_all("overflow");
    cycle(0, 0, 0); check_all("reject_pulse_end");
    cycle(2, 0, 0); check_all("overflow2");
    cycle(0, 0, 0); check_all("full_hold");
    cycle(0, 0, 0); check_all("perf_full");

    // Wraparound across index 15 -> 0 with order preserved.
    cycle(0, 0, 1); check_all("flush_full");
    repeat (3) begin cycle(4, 0, 0); check_all("wrap_push_a"); end
    repeat (6) begin cycle(0, 2, 0); check_all("wrap_pop_a"); end
    repeat (3) begin cycle(4, 0, 0); check_all("wrap_push_b"); end
    repeat (6) begin cycle(0, 2, 0); check_all("wrap_pop_b"); end

    // Over-pop clamped while pushing in the same cycle.
    cycle(1, 0, 0); check_all("one_entry");
    cycle(3, 2, 0); check_all("overpop_push");

    // Flush overrides simultaneous push and pop.
    cycle(4, 0, 0); cycle(3, 0, 0); check_all("size10");
    cycle(4, 2, 1); check_all("flush_override");

    // Asynchronous reset mid-operation.
    cycle(4, 0, 0); cycle(4, 1, 0); check_all("pre_rst");
    push_num = '0; pop_num = '0;
    #2 rst = 1'b1; #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk); rst = 1'b0; #1;
    check_all("rst_release2");

    // Random traffic, push-heavy so full and reject corners are exercised.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, PUSH_W), $urandom_range(0, POP_W), ($urandom_range(0, 39) == 0));
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
